// File: rtl/alu_operand_stage_if.sv
// Handshake/bus bundle between decode, the ALU operand stage and the ALU.
// The stage itself connects through the slave modport; the driving environment uses master.
interface alu_operand_stage_if #(
   parameter int WIDTH          = 32,
   parameter int CTRL_WIDTH     = 4,
   parameter int REG_ADDR_WIDTH = 5
);
   logic                      flush;
   logic                      in_valid;
   logic                      in_ready;
   logic [REG_ADDR_WIDTH-1:0] rs1_addr;
   logic [REG_ADDR_WIDTH-1:0] rs2_addr;
   logic [WIDTH-1:0]          rs1_data;
   logic [WIDTH-1:0]          rs2_data;
   logic [WIDTH-1:0]          pc;
   logic [WIDTH-1:0]          imm;
   logic                      use_pc;
   logic                      use_imm;
   logic [CTRL_WIDTH-1:0]     ctrl_in;
   logic                      wb_write;
   logic [REG_ADDR_WIDTH-1:0] wb_rd;
   logic [WIDTH-1:0]          wb_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          src_A;
   logic [WIDTH-1:0]          src_B;
   logic [CTRL_WIDTH-1:0]     ALU_control;

   modport master (
      output flush, in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, pc, imm,
             use_pc, use_imm, ctrl_in, wb_write, wb_rd, wb_data, out_ready,
      input  in_ready, out_valid, src_A, src_B, ALU_control
   );

   modport slave (
      input  flush, in_valid, rs1_addr, rs2_addr, rs1_data, rs2_data, pc, imm,
             use_pc, use_imm, ctrl_in, wb_write, wb_rd, wb_data, out_ready,
      output in_ready, out_valid, src_A, src_B, ALU_control
   );
endinterface

// File: rtl/alu_operand_stage.sv
// ALU operand stage: forms src_A/src_B at capture and buffers them in a 2-entry skid FIFO.
// Define ALU_OPERAND_FORWARD_EN to forward the writeback value into rs1/rs2 at capture.
module alu_operand_stage #(
   parameter int WIDTH          = 32,
   parameter int CTRL_WIDTH     = 4,
   parameter int REG_ADDR_WIDTH = 5
) (
   input logic                clock,
   input logic                reset,
   alu_operand_stage_if.slave bus
);

   typedef struct packed {
      logic [WIDTH-1:0]      a;
      logic [WIDTH-1:0]      b;
      logic [CTRL_WIDTH-1:0] ctrl;
   } entry_t;

   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   in_ready_q, in_ready_d;
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;

   logic [WIDTH-1:0] rs1_val;
   logic [WIDTH-1:0] rs2_val;
   entry_t           in_entry;
   logic             accept;
   logic             release_out;

`ifdef ALU_OPERAND_FORWARD_EN
   always_comb begin
      rs1_val = bus.rs1_data;
      rs2_val = bus.rs2_data;
      if (bus.wb_write && (bus.wb_rd == bus.rs1_addr) && (bus.wb_rd != '0)) rs1_val = bus.wb_data;
      if (bus.wb_write && (bus.wb_rd == bus.rs2_addr) && (bus.wb_rd != '0)) rs2_val = bus.wb_data;
   end
`else
   logic unused_wb;
   assign unused_wb = ^{bus.wb_write, bus.wb_rd, bus.wb_data};

   always_comb begin
      rs1_val = bus.rs1_data;
      rs2_val = bus.rs2_data;
   end
`endif

   // Register x0 always reads as zero, even if the read port returns garbage.
   always_comb begin
      in_entry      = '0;
      in_entry.a    = bus.use_pc  ? bus.pc  : ((bus.rs1_addr == '0) ? '0 : rs1_val);
      in_entry.b    = bus.use_imm ? bus.imm : ((bus.rs2_addr == '0) ? '0 : rs2_val);
      in_entry.ctrl = bus.ctrl_in;
   end

   assign accept      = bus.in_valid && in_ready_q;
   assign release_out = out_valid_q && bus.out_ready;

   // The skid entry always drains before new input; in_ready is low whenever it is full.
   always_comb begin
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      out_d        = out_q;
      skid_d       = skid_q;
      if (bus.flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || release_out) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = in_entry;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
      in_ready_d = !skid_valid_d;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         out_q        <= '0;
         skid_q       <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         out_q        <= out_d;
         skid_q       <= skid_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.src_A       = out_q.a;
   assign bus.src_B       = out_q.b;
   assign bus.ALU_control = out_q.ctrl;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline stage directly upstream of the ALU: captures decoded operands and control from the decode stage, forms src_A/src_B, and presents them with ALU_control to the ALU.
- Valid/ready handshake on both sides; 2-entry skid buffer gives full throughput with registered in_ready.
- Synchronous flush supports branch redirect.

Parameters:
- WIDTH, 32, datapath width of operands, pc, immediate.
- CTRL_WIDTH, 4, width of ALU_control.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous; discard all held and incoming entries.
- in_valid  input  1  decode stage presents an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- rs1_addr  input  REG_ADDR_WIDTH  source register 1 index.
- rs2_addr  input  REG_ADDR_WIDTH  source register 2 index.
- rs1_data  input  WIDTH  register file read data 1.
- rs2_data  input  WIDTH  register file read data 2.
- pc  input  WIDTH  instruction address.
- imm  input  WIDTH  sign-extended immediate.
- use_pc  input  1  src_A = pc instead of rs1.
- use_imm  input  1  src_B = imm instead of rs2.
- ctrl_in  input  CTRL_WIDTH  ALU operation code.
- wb_write  input  1  writeback stage writes a register (forwarding only).
- wb_rd  input  REG_ADDR_WIDTH  writeback destination (forwarding only).
- wb_data  input  WIDTH  writeback value (forwarding only).
- out_valid  output  1  src_A/src_B/ALU_control valid.
- out_ready  input  1  downstream consumes the entry.
- src_A  output  WIDTH  ALU operand A.
- src_B  output  WIDTH  ALU operand B.
- ALU_control  output  CTRL_WIDTH  ALU operation.

Behaviour:
- Reset (async, immediate): out_valid=0, skid_valid=0, src_A=0, src_B=0, ALU_control=0; in_ready=1 once reset deasserts.
- Operand formation happens at capture, not at output:
  - A_eff = use_pc ? pc : (rs1_addr==0 ? 0 : rs1_val).
  - B_eff = use_imm ? imm : (rs2_addr==0 ? 0 : rs2_val).
  - rs1_val/rs2_val are the raw read data, or the forwarded value (see Optional Feature).
- Acceptance: accept when in_valid && in_ready. Release: when out_valid && out_ready.
- in_ready = !skid_valid; it is a registered signal with no combinational path from out_ready.
- Capture rules, per rising edge with no flush:
  - Output empty, or output released this cycle: output loads skid if skid_valid (skid_valid->0), else loads the accepted input. If neither exists and the output was released, out_valid->0.
  - Output held (valid, not released) and input accepted: entry goes to skid, skid_valid->1.
  - Skid full and output released in the same cycle as an input arrives: skid moves to output; in_ready was 0, so the input is not accepted.
- Latency: 1 cycle from acceptance to out_valid with an empty stage. Throughput: 1 entry/cycle while out_ready=1.
- Ordering: strictly FIFO, 2 entries maximum.
- Stability: outputs must not change while out_valid && !out_ready.
- Flush: next edge forces out_valid=0 and skid_valid=0. An input accepted in the flush cycle is discarded. Data registers may hold stale values. Flush takes priority over all capture rules.
- Reset mid-transfer: entries are lost; no output pulse.

Optional Feature:
- Macro: ALU_OPERAND_FORWARD_EN.
- Defined:
  - rs1_val = (wb_write && wb_rd==rs1_addr && wb_rd!=0) ? wb_data : rs1_data; same rule for rs2_val.
  - Applied at capture only. An entry parked in skid keeps its captured values.
- Undefined:
  - rs1_val=rs1_data and rs2_val=rs2_data.
  - wb_* ports remain present but are ignored.

Test Plan:
- Reset during traffic with out_valid=1 -> out_valid=0, src_A=0, src_B=0, ALU_control=0 immediately; in_ready=1 after deassert.
- rs1_data=5, rs2_data=7, use_pc=0, use_imm=0, ctrl_in=4'b0001, out_ready=1 -> next cycle out_valid=1, src_A=5, src_B=7, ALU_control=4'b0001.
- rs1_addr=0, rs1_data=32'hDEAD, use_imm=1, imm=32'hFFFFFFFC; then use_pc=1, pc=32'h100 -> src_A=0, src_B=32'hFFFFFFFC; then src_A=32'h100.
- out_ready=0, stream entries E1,E2,E3 -> E1 held on output, E2 in skid, in_ready=0, E3 stalled. Raise out_ready -> E1,E2,E3 appear on consecutive cycles, none lost or duplicated.
- Two entries held, flush=1 for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
- ALU_OPERAND_FORWARD_EN defined:
  - wb_write=1, wb_rd=3, wb_data=9, rs1_addr=3, rs1_data=1 -> src_A=9.
  - Same with wb_rd=0 and rs1_addr=0 -> src_A=0.
  - Macro undefined -> src_A=1.
